// File: rtl/mfcc_norm_stream.sv
// Per-coefficient running mean (shared restoring divider), mean subtraction and reciprocal scaling,
// streamed out with valid/ready. Latency ACC_W+2 cycles per coefficient; out_data held until out_ready.
module mfcc_norm_stream #(
    parameter int NUM_COEF   = 26,
    parameter int ADDR_W     = 8,
    parameter int IN_W       = 16,
    parameter int FRAC_W     = 16,
    parameter int ACC_W      = 40,
    parameter int SCALE_W    = 24,
    parameter int OUT_W      = 24,
    parameter int FRAME_SKIP = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        frame_num,
    input  logic [IN_W-1:0]   wr_data,
    input  logic              clear,
    input  logic              start,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ACC_W-1:0]  cfg_data,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              div_zero,
    output logic              sat
);

    localparam int IDX_W  = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam int CNT_W  = $clog2(ACC_W);
    localparam int PROD_W = ACC_W + SCALE_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_NORM, S_OUT, S_FIN} state_t;
    state_t state_q;

    logic [ACC_W-1:0]   acc_q  [NUM_COEF];
    logic [ACC_W-1:0]   mean_q [NUM_COEF];
    logic [SCALE_W-1:0] inv_q  [NUM_COEF];

    logic [IDX_W-1:0]   idx_q, wr_idx, cfg_idx;
    logic [7:0]         count_q, count_d;
    logic [CNT_W-1:0]   div_cnt_q;
    logic [ACC_W-1:0]   quo_q, quo_d, avg_q, mean_lat_q, acc_mag, dvd;
    logic [SCALE_W-1:0] inv_lat_q;
    logic [7:0]         rem_q, rem_d, rem_in;
    logic [8:0]         trial, trial_sub;
    logic               q_bit, neg_q, div_first, div_last;
    logic [OUT_W-1:0]   out_data_q, norm_d;
    logic               clip;
    logic               out_valid_q, out_last_q, busy_q, done_q, overrun_q, div_zero_q, sat_q;
    logic               idle, wr_ok, cfg_ok;
    logic [ACC_W-1:0]   wr_ext;

    logic signed [PROD_W-1:0] diff_ext, scl_ext, prod, res;

    assign idle    = (state_q == S_IDLE);
    assign wr_idx  = wr_addr[IDX_W-1:0];
    assign cfg_idx = cfg_addr[IDX_W-1:0];
    assign wr_ok   = idle && wr_en && (wr_addr < ADDR_W'(NUM_COEF)) && (frame_num >= 8'(FRAME_SKIP));
    assign cfg_ok  = cfg_we && (cfg_addr < ADDR_W'(NUM_COEF));
    assign wr_ext  = {{(ACC_W-IN_W-FRAC_W){wr_data[IN_W-1]}}, wr_data, {FRAC_W{1'b0}}};
    assign count_d = (frame_num >= 8'(FRAME_SKIP)) ? frame_num - 8'(FRAME_SKIP) : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEF; i++) acc_q[i] <= '0;
        end else if (idle && clear) begin
            for (int i = 0; i < NUM_COEF; i++) acc_q[i] <= '0;
        end else if (wr_ok) begin
            acc_q[wr_idx] <= acc_q[wr_idx] + wr_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                mean_q[i] <= '0;
                inv_q[i]  <= '0;
            end
        end else if (cfg_ok) begin
            if (cfg_sel) inv_q[cfg_idx]  <= cfg_data[SCALE_W-1:0];
            else         mean_q[cfg_idx] <= cfg_data;
        end
    end

    // One restoring step per cycle; the first step reads the magnitude straight from the accumulator.
    always_comb begin
        acc_mag   = acc_q[idx_q][ACC_W-1] ? (~acc_q[idx_q] + 1'b1) : acc_q[idx_q];
        div_first = (div_cnt_q == '0);
        div_last  = (div_cnt_q == CNT_W'(ACC_W-1));
        dvd       = div_first ? acc_mag : quo_q;
        rem_in    = div_first ? 8'd0 : rem_q;
        trial     = {rem_in, dvd[ACC_W-1]};
        trial_sub = trial - {1'b0, count_q};
        q_bit     = (trial >= {1'b0, count_q});
        rem_d     = q_bit ? trial_sub[7:0] : trial[7:0];
        quo_d     = {dvd[ACC_W-2:0], q_bit};
    end

    always_comb begin
        diff_ext = $signed({{(PROD_W-ACC_W){avg_q[ACC_W-1]}}, avg_q})
                 - $signed({{(PROD_W-ACC_W){mean_lat_q[ACC_W-1]}}, mean_lat_q});
        scl_ext  = $signed({{(PROD_W-SCALE_W){1'b0}}, inv_lat_q});
        prod     = diff_ext * scl_ext;
        res      = prod >>> FRAC_W;
        clip     = !((&res[PROD_W-1:OUT_W-1]) || !(|res[PROD_W-1:OUT_W-1]));
        norm_d   = res[OUT_W-1:0];
        if (clip) norm_d = res[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            div_cnt_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            neg_q       <= 1'b0;
            avg_q       <= '0;
            mean_lat_q  <= '0;
            inv_lat_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        overrun_q  <= 1'b0;
                        div_zero_q <= 1'b0;
                        sat_q      <= 1'b0;
                    end
                    if (start) begin
                        count_q   <= count_d;
                        idx_q     <= '0;
                        div_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (div_first) begin
                        // Table entries are frozen here so mid-coefficient cfg writes only affect later passes.
                        mean_lat_q <= mean_q[idx_q];
                        inv_lat_q  <= inv_q[idx_q];
                        neg_q      <= acc_q[idx_q][ACC_W-1];
                    end
                    if (div_first && count_q == 8'd0) begin
                        avg_q      <= '0;
                        div_zero_q <= 1'b1;
                        state_q    <= S_NORM;
                    end else begin
                        quo_q     <= quo_d;
                        rem_q     <= rem_d;
                        div_cnt_q <= div_cnt_q + 1'b1;
                        if (div_last) begin
                            avg_q   <= neg_q ? (~quo_d + 1'b1) : quo_d;
                            state_q <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    out_data_q  <= norm_d;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (idx_q == IDX_W'(NUM_COEF-1));
                    if (clip) sat_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            div_cnt_q <= '0;
                            state_q   <= S_DIV;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (wr_en && !idle) overrun_q <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign div_zero  = div_zero_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mfcc_norm_stream.sv
// Scoreboard bench for mfcc_norm_stream: expected coefficients are queued at start and popped on handshake.
module tb_mfcc_norm_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, clear, start, cfg_we, cfg_sel, out_ready;
    logic [7:0]  wr_addr, frame_num, cfg_addr;
    logic [15:0] wr_data;
    logic [39:0] cfg_data;
    logic [23:0] out_data;
    logic        out_valid, out_last, busy, done, overrun, div_zero, sat;

    always #5 clk = ~clk;

    mfcc_norm_stream dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .frame_num(frame_num),
        .wr_data(wr_data), .clear(clear), .start(start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .overrun(overrun), .div_zero(div_zero), .sat(sat)
    );

    int          checks = 0;
    int          errors = 0;
    longint      m_acc  [26];
    longint      m_mean [26];
    longint      m_inv  [26];
    bit          m_ovr, m_dz, m_sat;
    logic [23:0] exp_q [$];
    logic [23:0] cap [26];
    int          lat_first;

    function automatic logic [23:0] model_out(input int c, input int cnt, output bit clip);
        longint             avg;
        logic signed [127:0] d, s, p, r;
        avg  = (cnt == 0) ? 64'sd0 : m_acc[c] / longint'(cnt);
        d    = avg - m_mean[c];
        s    = m_inv[c];
        p    = d * s;
        r    = p >>> 16;
        clip = 1'b0;
        if (r > 128'sd8388607) begin
            r = 128'sd8388607; clip = 1'b1;
        end else if (r < -128'sd8388608) begin
            r = -128'sd8388608; clip = 1'b1;
        end
        return r[23:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 26; i++) begin
            m_acc[i] = 0; m_mean[i] = 0; m_inv[i] = 0;
        end
        m_ovr = 0; m_dz = 0; m_sat = 0;
        exp_q.delete();
    endtask

    task automatic drive_write(input int addr, input int fnum, input int data);
        logic [15:0] d16;
        d16 = data[15:0];
        wr_en = 1'b1; wr_addr = addr[7:0]; frame_num = fnum[7:0]; wr_data = d16;
        tick;
        wr_en = 1'b0;
        if (addr < 26 && fnum >= 6) m_acc[addr] += longint'($signed(d16)) * 65536;
    endtask

    task automatic drive_cfg(input bit sel, input int addr, input longint val);
        logic [39:0] v40;
        v40 = val[39:0];
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr[7:0]; cfg_data = v40;
        tick;
        cfg_we = 1'b0;
        if (addr < 26) begin
            if (sel) m_inv[addr] = longint'(v40[23:0]);
            else     m_mean[addr] = longint'($signed(v40));
        end
    endtask

    task automatic drive_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        for (int i = 0; i < 26; i++) m_acc[i] = 0;
        m_ovr = 0; m_dz = 0; m_sat = 0;
    endtask

    task automatic run_pass(input int fnum, input int stall_coef, input bit wr_in_pass);
        int          cnt, popped, stall;
        bit          clip, saw_done;
        logic [23:0] held, e;
        cnt   = (fnum >= 6) ? fnum - 6 : 0;
        stall = stall_coef;
        for (int c = 0; c < 26; c++) begin
            e = model_out(c, cnt, clip);
            exp_q.push_back(e);
            if (clip) m_sat = 1;
        end
        if (cnt == 0) m_dz = 1;
        if (wr_in_pass) m_ovr = 1;
        frame_num = fnum[7:0]; start = 1'b1; out_ready = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        popped = 0; saw_done = 0; lat_first = -1;
        for (int cyc = 1; cyc < 3000 && !saw_done; cyc++) begin
            tick;
            wr_en = 1'b0;
            if (wr_in_pass && cyc == 2) begin
                wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'd1000; frame_num = 8'd10;
            end
            if (done === 1'b1) begin
                saw_done = 1;
                checks++;
                if (popped != 26) begin errors++; $display("FAIL done_early: got %0d outputs want 26", popped); end
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL fin_state: valid=%b busy=%b want 0 0", out_valid, busy);
                end
            end else if (out_valid === 1'b1) begin
                if (lat_first < 0) lat_first = cyc;
                if (popped == stall) begin
                    out_ready = 1'b0;
                    held = out_data;
                    repeat (5) begin
                        tick;
                        checks++;
                        if (out_valid !== 1'b1 || out_data !== held) begin
                            errors++;
                            $display("FAIL stall_hold: valid=%b data=%h want 1 %h", out_valid, out_data, held);
                        end
                    end
                    out_ready = 1'b1;
                    stall = -1;
                end
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_output: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++; $display("FAIL coef%0d_data: got %h want %h", popped - 1, out_data, e);
                    end
                end
                checks++;
                if (out_last !== (popped == 26)) begin
                    errors++; $display("FAIL coef%0d_last: got %b want %b", popped - 1, out_last, popped == 26);
                end
                if (popped <= 26) cap[popped-1] = out_data;
            end
        end
        wr_en = 1'b0;
        checks++;
        if (!saw_done) begin errors++; $display("FAIL done_timeout: got no done want done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL missing_outputs: got %0d left want 0", exp_q.size()); end
        checks++;
        if (sat !== m_sat || div_zero !== m_dz || overrun !== m_ovr) begin
            errors++;
            $display("FAIL sticky: got sat=%b dz=%b ovr=%b want %b %b %b", sat, div_zero, overrun, m_sat, m_dz, m_ovr);
        end
        tick;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wr_en = 0; clear = 0; start = 0; cfg_we = 0; cfg_sel = 0; out_ready = 1;
        wr_addr = 0; frame_num = 0; cfg_addr = 0; wr_data = 0; cfg_data = 0;
        model_reset();
        repeat (2) tick;
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++;
        if ({overrun, div_zero, sat} !== 3'b000) begin
            errors++; $display("FAIL rst_sticky: got %b%b%b want 000", overrun, div_zero, sat);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        for (int c = 0; c < 26; c++) drive_cfg(1'b1, c, 64'h10000);
        for (int f = 6; f <= 9; f++)
            for (int c = 0; c < 26; c++) drive_write(c, f, (c == 0) ? 100 : 0);
        drive_write(26, 6, 1000);
        drive_write(200, 7, 1000);
        run_pass(10, -1, 1'b0);
        checks++; if (cap[0] !== 24'h640000) begin errors++; $display("FAIL basic_coef0: got %h want 640000", cap[0]); end
        checks++; if (cap[25] !== 24'h0) begin errors++; $display("FAIL basic_coef25: got %h want 0", cap[25]); end
        checks++; if (lat_first != 41) begin errors++; $display("FAIL first_latency: got %0d want 41", lat_first); end
    endtask

    task automatic test_skip_and_mean;
        drive_clear();
        drive_write(0, 3, 500);
        for (int f = 6; f <= 7; f++) begin
            drive_write(0, f, 10);
            drive_write(1, f, -100);
        end
        drive_cfg(1'b0, 1, 64'hA0000);
        drive_cfg(1'b1, 1, 64'h8000);
        run_pass(8, -1, 1'b0);
        checks++; if (cap[0] !== 24'h0A0000) begin errors++; $display("FAIL skip_coef0: got %h want 0a0000", cap[0]); end
        checks++; if (cap[1] !== 24'hC90000) begin errors++; $display("FAIL mean_coef1: got %h want c90000", cap[1]); end
    endtask

    task automatic test_sat_backpressure;
        drive_clear();
        drive_write(2, 6, 200);
        drive_write(3, 6, 7);
        run_pass(7, 3, 1'b1);
        checks++; if (cap[2] !== 24'h7FFFFF) begin errors++; $display("FAIL sat_coef2: got %h want 7fffff", cap[2]); end
        checks++; if (cap[3] !== 24'h070000) begin errors++; $display("FAIL stall_coef3: got %h want 070000", cap[3]); end
        run_pass(7, -1, 1'b0);
        checks++; if (cap[5] !== 24'h0) begin errors++; $display("FAIL dropped_write: got %h want 0", cap[5]); end
        checks++; if (cap[3] !== 24'h070000) begin errors++; $display("FAIL retained_acc: got %h want 070000", cap[3]); end
    endtask

    task automatic test_div_zero;
        drive_clear();
        drive_cfg(1'b0, 4, 64'h30000);
        drive_cfg(1'b0, 7, 64'h100000000);
        run_pass(6, -1, 1'b0);
        checks++; if (cap[4] !== 24'hFD0000) begin errors++; $display("FAIL dz_coef4: got %h want fd0000", cap[4]); end
        checks++; if (cap[7] !== 24'h800000) begin errors++; $display("FAIL dz_coef7: got %h want 800000", cap[7]); end
        checks++; if (cap[1] !== 24'hFB0000) begin errors++; $display("FAIL dz_coef1: got %h want fb0000", cap[1]); end
    endtask

    task automatic test_reset_mid_pass;
        bit seen;
        drive_write(0, 6, 50);
        out_ready = 1'b0; frame_num = 8'd10; start = 1'b1;
        tick;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick;
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_reach_out: got no valid want valid"); end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 24'h0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got v=%b b=%b d=%h l=%b want 0", out_valid, busy, out_data, out_last);
        end
        tick;
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (done === 1'b1 || out_valid === 1'b1 || busy === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_done: got activity after reset want none"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip_and_mean();
        test_sat_backpressure();
        test_div_zero();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfcc_norm_stream.md
Name: mfcc_norm_stream

Overview:
- Parametrised successor to the MFCC mean/scale memory stage.
- Accumulates per-coefficient MFCC values across frames and computes the per-coefficient mean with one shared sequential divider.
- Applies mean subtraction and reciprocal-scale normalisation, then streams the normalised coefficients into the classifier's input stream with valid/ready backpressure.

Parameters:
- NUM_COEF, 26, coefficients per frame
- ADDR_W, 8, coefficient address width
- IN_W, 16, signed input sample width
- FRAC_W, 16, fractional bits of the internal fixed-point format
- ACC_W, 40, signed accumulator, mean and average width
- SCALE_W, 24, unsigned reciprocal-scale width (Q(SCALE_W-FRAC_W).FRAC_W)
- OUT_W, 24, signed output width
- FRAME_SKIP, 6, first frame_num that is accumulated

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- wr_en  in  1  coefficient write strobe
- wr_addr  in  ADDR_W  coefficient index
- frame_num  in  8  current frame number
- wr_data  in  IN_W  signed coefficient value
- clear  in  1  zero accumulators and sticky flags
- start  in  1  begin normalise-and-stream pass
- cfg_we  in  1  config write
- cfg_sel  in  1  0 = mean table, 1 = inv_scale table
- cfg_addr  in  ADDR_W  table index
- cfg_data  in  ACC_W  table data (inv_scale uses low SCALE_W bits)
- out_data  out  OUT_W  normalised coefficient
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream ready
- out_last  out  1  final coefficient of pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end
- overrun  out  1  sticky: write attempted while busy
- div_zero  out  1  sticky: start with zero frame count
- sat  out  1  sticky: output saturated

Behaviour:
- Reset: all outputs 0; accumulators, tables and state cleared; FSM in IDLE.
- Accumulate (IDLE only):
  - If wr_en, wr_addr < NUM_COEF and frame_num >= FRAME_SKIP: acc[wr_addr] += sign_ext(wr_data) << FRAC_W.
  - Addresses >= NUM_COEF are ignored.
  - wr_en while busy sets overrun; the write is dropped.
- clear (IDLE only): zeroes acc and all sticky flags; ignored while busy.
- cfg_we writes a table entry in any state; an entry for the coefficient currently being processed takes effect only for later passes.
- start in IDLE:
  - Latch count = frame_num - FRAME_SKIP, as unsigned 8-bit, clamped to 0 if frame_num < FRAME_SKIP.
  - busy=1, idx=0, go to DIV. start while busy is ignored. start and wr_en in the same cycle: the write is applied first.
- DIV:
  - Restoring divide of |acc[idx]| by count, one quotient bit per cycle, ACC_W cycles.
  - Quotient sign = acc sign; truncation toward zero.
  - If count = 0: avg = 0, div_zero set, DIV takes 1 cycle.
- NORM, 1 cycle:
  - diff = avg - mean[idx] (ACC_W+1 bits)
  - prod = diff * inv_scale (signed × unsigned)
  - res = prod >>> FRAC_W (arithmetic)
  - Saturate res to signed OUT_W range; set sat on clip.
- OUT:
  - out_valid=1, out_data=res, out_last=(idx==NUM_COEF-1).
  - Data is held stable until out_ready is sampled high.
  - On handshake: if last, go to FIN; else idx+1 and back to DIV.
- FIN: done=1 for one cycle, busy=0, go to IDLE. Accumulators are retained (running mean); only clear zeroes them.
- Latency per coefficient with out_ready=1: ACC_W+2 cycles from entering DIV to handshake (count≠0).
- Asynchronous reset mid-pass aborts immediately with no done pulse.

Test Plan:
- Defaults; mean=0, inv_scale=0x010000; frames 6..9 write 100 to coef 0, 0 elsewhere; start with frame_num=10 -> coef0 out_data=0x640000, coefs 1..25 = 0, out_last on 26th, done one cycle later.
- Writes with frame_num=3 (value 500, coef 0), then frames 6,7 write 10 -> after start with frame_num=8, coef0 = 0x0A0000.
- Coef 1: frames 6,7 write 0xFF9C (-100); mean[1]=0x0A0000; inv_scale[1]=0x008000; start with frame_num=8 -> out_data=0xC90000 (-55.0).
- Frame 6 writes 200 to coef 2 with inv_scale=1.0; start with frame_num=7 -> out_data=0x7FFFFF, sat=1.
- out_ready held low 5 cycles during coef 3 -> out_valid and out_data stable, no idx advance; wr_en during the pass -> overrun=1 and acc unchanged after done.
- start with frame_num=6 -> div_zero=1, all outputs = saturated -mean.
- Assert reset during OUT -> outputs 0, busy 0, no done pulse.
